gemm_result_collector: RTL
==========================

Name: gemm_result_collector

Overview:
Sink-side counterpart to the fixed-weight GEMM systolic array. It captures the result vectors the array emits each cycle once its output_valid is high, and groups every NUM_ROWS accepted vectors into one result tile. Storage is a two-bank ping-pong buffer. Completed tiles are streamed downstream one row per valid/ready handshake, and the block flags when a result vector is lost to backpressure.

Parameters:
SA_SIZE, 3, number of elements per result vector (array width)
WEIGHT_ACTIVATION_SIZE, 8, bit width of each element
NUM_ROWS, 4, number of result vectors per tile; must be >= 2

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  result vector valid; driven by the array's output_valid
in_data  in  SA_SIZE x WEIGHT_ACTIVATION_SIZE  result vector from the array
capture_en  in  1  vectors are accepted only while high
in_ready  out  1  status: current write bank is not full
out_valid  out  1  a full tile row is presented
out_ready  in  1  downstream accepts the row
out_data  out  SA_SIZE x WEIGHT_ACTIVATION_SIZE  row data
out_row_idx  out  $clog2(NUM_ROWS)  row index within the tile
out_last  out  1  high with the final row of a tile
overflow  out  1  sticky: a vector was dropped
clear_overflow  in  1  clears overflow

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: banks empty, wr_bank=0, wr_row=0, rd_bank=0, rd_row=0, out_valid=0, out_last=0, out_row_idx=0, overflow=0, in_ready=1. Asserting reset mid-tile discards partial and full tiles.
- Accept condition: in_valid && capture_en && !full[wr_bank].
  - On accept, in_data is written to bank[wr_bank] row wr_row, and wr_row increments.
  - On the accept where wr_row==NUM_ROWS-1: set full[wr_bank], reset wr_row to 0, toggle wr_bank.
- Drop condition: in_valid && capture_en && full[wr_bank]. The vector is discarded and overflow is set the next cycle.
- Write side states: FILLING, meaning wr_row counts 0 to NUM_ROWS-1 in the current bank. Both-banks-full is not a state; it is the drop condition above.
- Read side states: IDLE and DRAIN.
  - IDLE -> DRAIN when full[rd_bank]=1. out_valid rises the cycle after the last row of a tile is accepted, so tile-completion latency is 1 cycle.
  - In DRAIN: out_valid=1 and out_data = bank[rd_bank][rd_row] (combinational read). out_row_idx = rd_row. out_last = (rd_row==NUM_ROWS-1).
  - On out_valid && out_ready: rd_row increments.
  - On the last row handshake: clear full[rd_bank], reset rd_row to 0, toggle rd_bank. Next state is DRAIN if the other bank is full, else IDLE, with no bubble between tiles.
- Handshake rules: out_data, out_row_idx and out_last are held stable while out_valid && !out_ready. out_valid never drops without a handshake except on reset.
- Same-cycle free and write: if the last row handshake frees the bank that wr_bank targets and an in_valid vector arrives in that cycle, full is evaluated before the edge, so the vector is dropped and overflow is set.
- in_ready = !full[wr_bank], combinational. It is advisory only; the array cannot stall.
- overflow: clear_overflow clears it. A drop in the same cycle as clear_overflow wins, so overflow ends up set.
- Data is stored unmodified. No arithmetic is performed.

Optional Feature:
GEMM_COLLECTOR_DROP_COUNT_EN
- Defined: adds output drop_count [15:0]. It increments by 1 per dropped vector, saturates at 16'hFFFF, resets to 0, and is cleared by clear_overflow with the same priority rule as overflow (a same-cycle drop leaves the count at 1).
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- GEMM_pkg gains a typedef result_vec_t (array of SA_SIZE elements of WEIGHT_ACTIVATION_SIZE bits) and a typedef collector_rd_state_t {IDLE, DRAIN}.
- Sub-module gemm_collector_bank: one tile of NUM_ROWS x result_vec_t storage with write port (we, waddr, wdata) and combinational read port (raddr, rdata). It is instantiated twice.

Test Plan:
- Reset, then 4 accepted vectors {1,2,3}..{10,11,12} with out_ready=1 -> out_valid rises the cycle after the 4th; rows 0..3 are output in order with out_last only on row 3; overflow stays 0.
- out_ready=0 while 8 vectors arrive -> both banks full, in_ready=0. The 9th vector is dropped and overflow=1 the next cycle. Releasing out_ready then drains 8 rows matching the first 8 inputs.
- out_ready toggling 1,0,1,0 during a drain -> out_data and out_row_idx are held while stalled; no row is duplicated or skipped.
- capture_en=0 while in_valid=1 for 5 cycles -> nothing is captured and out_valid stays 0. With capture_en=1, the next 4 vectors form the tile.
- Reset asserted after 2 of 4 vectors -> the next tile starts at row 0; the earlier 2 vectors never appear.
- Last row handshake of a tile in the same cycle a vector arrives while both banks are full -> the vector is dropped and overflow=1. With GEMM_COLLECTOR_DROP_COUNT_EN defined, drop_count=1 in this scenario; after 70000 drops, drop_count=16'hFFFF.

Source files
------------

// File: rtl/gemm_result_collector_pkg.sv
// Shared types for the GEMM result collector: the result vector layout and the
// read-side state encoding.
package gemm_result_collector_pkg;

    localparam int GEMM_SA_SIZE  = 3;
    localparam int GEMM_WA_SIZE  = 8;
    localparam int GEMM_NUM_ROWS = 4;

    typedef logic [GEMM_SA_SIZE-1:0][GEMM_WA_SIZE-1:0] result_vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } collector_rd_state_t;

endpackage

// File: rtl/gemm_collector_bank.sv
// One result tile of storage: a synchronous write port and a combinational read
// port. Contents are not reset; validity is tracked by the collector.
module gemm_collector_bank
    import gemm_result_collector_pkg::*;
#(
    parameter int SA_SIZE                = GEMM_SA_SIZE,
    parameter int WEIGHT_ACTIVATION_SIZE = GEMM_WA_SIZE,
    parameter int NUM_ROWS               = GEMM_NUM_ROWS,
    localparam int ROW_W                 = $clog2(NUM_ROWS)
) (
    input  logic                                            clk,
    input  logic                                            we,
    input  logic [ROW_W-1:0]                                waddr,
    input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] wdata,
    input  logic [ROW_W-1:0]                                raddr,
    output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] rdata
);

    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] r_mem [NUM_ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/gemm_result_collector.sv
// Collects systolic-array result vectors into NUM_ROWS-row tiles in a ping-pong
// buffer and streams finished tiles out row by row. GEMM_COLLECTOR_DROP_COUNT_EN
// adds a saturating drop_count output.
module gemm_result_collector
    import gemm_result_collector_pkg::*;
#(
    parameter int SA_SIZE                = GEMM_SA_SIZE,
    parameter int WEIGHT_ACTIVATION_SIZE = GEMM_WA_SIZE,
    parameter int NUM_ROWS               = GEMM_NUM_ROWS,
    localparam int ROW_W                 = $clog2(NUM_ROWS)
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            in_valid,
    input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] in_data,
    input  logic                                            capture_en,
    output logic                                            in_ready,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] out_data,
    output logic [ROW_W-1:0]                                out_row_idx,
    output logic                                            out_last,
    output logic                                            overflow,
    input  logic                                            clear_overflow
`ifdef GEMM_COLLECTOR_DROP_COUNT_EN
    ,
    output logic [15:0]                                     drop_count
`endif
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    logic [1:0]            r_full;
    logic                  r_wr_bank;
    logic [ROW_W-1:0]      r_wr_row;
    logic                  r_rd_bank;
    logic [ROW_W-1:0]      r_rd_row;
    logic                  r_overflow;
    collector_rd_state_t   r_rd_state;

    collector_rd_state_t   w_rd_state_nxt;
    logic [1:0]            w_full_nxt;
    logic                  w_wr_full;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_wr_last;
    logic                  w_rd_last;
    logic                  w_out_valid;
    logic                  w_rd_hs;
    logic                  w_rd_done;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] w_rdata0;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] w_rdata1;

    // Fullness is sampled before the edge, so a bank freed this cycle still rejects.
    assign w_wr_full   = r_full[r_wr_bank];
    assign w_accept    = in_valid && capture_en && !w_wr_full;
    assign w_drop      = in_valid && capture_en && w_wr_full;
    assign w_wr_last   = (r_wr_row == LAST_ROW);
    assign w_rd_last   = (r_rd_row == LAST_ROW);
    assign w_out_valid = (r_rd_state == DRAIN);
    assign w_rd_hs     = w_out_valid && out_ready;
    assign w_rd_done   = w_rd_hs && w_rd_last;

    // The drained bank is always full and the write bank never is, so the two
    // updates below can never target the same bank.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_done) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_accept && w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            IDLE: begin
                if (w_full_nxt[r_rd_bank]) begin
                    w_rd_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_rd_done) begin
                    w_rd_state_nxt = w_full_nxt[~r_rd_bank] ? DRAIN : IDLE;
                end
            end
            default: w_rd_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_wr_row   <= '0;
            r_rd_bank  <= 1'b0;
            r_rd_row   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wr_row <= w_wr_last ? '0 : r_wr_row + ROW_W'(1);
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_rd_hs) begin
                r_rd_row <= w_rd_last ? '0 : r_rd_row + ROW_W'(1);
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    gemm_collector_bank #(
        .SA_SIZE               (SA_SIZE),
        .WEIGHT_ACTIVATION_SIZE(WEIGHT_ACTIVATION_SIZE),
        .NUM_ROWS              (NUM_ROWS)
    ) u_bank0 (
        .clk  (clk),
        .we   (w_accept && (r_wr_bank == 1'b0)),
        .waddr(r_wr_row),
        .wdata(in_data),
        .raddr(r_rd_row),
        .rdata(w_rdata0)
    );

    gemm_collector_bank #(
        .SA_SIZE               (SA_SIZE),
        .WEIGHT_ACTIVATION_SIZE(WEIGHT_ACTIVATION_SIZE),
        .NUM_ROWS              (NUM_ROWS)
    ) u_bank1 (
        .clk  (clk),
        .we   (w_accept && (r_wr_bank == 1'b1)),
        .waddr(r_wr_row),
        .wdata(in_data),
        .raddr(r_rd_row),
        .rdata(w_rdata1)
    );

    assign in_ready    = !w_wr_full;
    assign out_valid   = w_out_valid;
    assign out_data    = r_rd_bank ? w_rdata1 : w_rdata0;
    assign out_row_idx = r_rd_row;
    assign out_last    = w_out_valid && w_rd_last;
    assign overflow    = r_overflow;

`ifdef GEMM_COLLECTOR_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= 16'd0;
        end else if (clear_overflow) begin
            r_drop_count <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop) begin
            r_drop_count <= sat_inc16(r_drop_count);
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule
